// File: rtl/keypad_calc_core.sv
// rtl/keypad_calc_core.sv - debounced two-operand BCD keypad calculator core
// Collects two DIGITS-digit BCD operands and runs a digit-serial signed add/subtract.
module keypad_calc_core #(
  parameter int DIGITS     = 5,
  parameter int DEB_CYCLES = 4,
  parameter int REL_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  press,
  input  logic [3:0]            scan_code,
  output logic                  key_valid,
  output logic [DIGITS-1:0]     buf_flag_1,
  output logic [4*DIGITS-1:0]   key_buf_code_1,
  output logic [DIGITS-1:0]     buf_flag_2,
  output logic [4*DIGITS-1:0]   key_buf_code_2,
  output logic                  op_sub,
  output logic                  busy,
  output logic [4*DIGITS+3:0]   result,
  output logic [DIGITS:0]       result_flag,
  output logic                  result_neg,
  output logic                  result_valid
);

  localparam int DW  = 4 * DIGITS;
  localparam int RW  = 4 * (DIGITS + 1);
  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam int RCW = $clog2(REL_CYCLES + 1);
  localparam int IW  = $clog2(DIGITS + 1);
  localparam logic [DCW-1:0] DEB_MAX  = DCW'(DEB_CYCLES);
  localparam logic [RCW-1:0] REL_MAX  = RCW'(REL_CYCLES);
  localparam logic [IW-1:0]  IDX_LAST = IW'(DIGITS);
  localparam logic [3:0] KEY_ADD = 4'hA, KEY_SUB = 4'hB, KEY_CLR = 4'hC,
                         KEY_EQ  = 4'hE, KEY_BS  = 4'hF;

  typedef enum logic [1:0] {ENTER_1, ENTER_2, CALC, SHOW} state_t;

  state_t          state;
  logic [3:0]      prev_code, key_code;
  logic [DCW-1:0]  deb_cnt, deb_next;
  logic [RCW-1:0]  rel_cnt, rel_next;
  logic            armed, accept;
  logic [DW-1:0]   x_sr, y_sr, acc;
  logic            cy, cy_next, neg_r;
  logic [IW-1:0]   idx;
  logic [4:0]      s;
  logic [3:0]      dig;
  logic [RW-1:0]   mag;

  function automatic logic [DIGITS:0] sig_mask(input logic [RW-1:0] m);
    logic [DIGITS:0] f;
    logic any;
    any = 1'b0;
    f = '0;
    for (int i = DIGITS; i >= 0; i--) begin
      any  = any | (m[4*i +: 4] != 4'h0);
      f[i] = any;
    end
    f[0] = 1'b1;
    return f;
  endfunction

  always_comb begin
    deb_next = '0;
    if (press && scan_code == prev_code)
      deb_next = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + 1'b1;
    rel_next = '0;
    if (!press)
      rel_next = (rel_cnt == REL_MAX) ? rel_cnt : rel_cnt + 1'b1;
    accept = armed && (deb_next == DEB_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_code <= '0;
      key_code  <= '0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      armed     <= 1'b1;
      key_valid <= 1'b0;
    end else begin
      prev_code <= scan_code;
      deb_cnt   <= deb_next;
      rel_cnt   <= rel_next;
      key_valid <= accept;
      if (accept) begin
        key_code <= scan_code;
        armed    <= 1'b0;
      end else if (rel_next == REL_MAX) begin
        armed <= 1'b1;
      end
    end
  end

  // One BCD digit per cycle; cy doubles as carry (add) or borrow (subtract).
  always_comb begin
    s       = '0;
    cy_next = 1'b0;
    if (!op_sub) begin
      s = {1'b0, x_sr[3:0]} + {1'b0, y_sr[3:0]} + {4'b0, cy};
      if (s > 5'd9) begin
        s       = s + 5'd6;
        cy_next = 1'b1;
      end
    end else begin
      s = {1'b0, x_sr[3:0]} - {1'b0, y_sr[3:0]} - {4'b0, cy};
      if (s[4]) begin
        s       = s + 5'd10;
        cy_next = 1'b1;
      end
    end
    dig = s[3:0];
    mag = {(op_sub ? 4'h0 : {3'b0, cy_next}), dig, acc[DW-1:4]};
  end

  logic is_digit, is_op, do_clear;
  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code == KEY_ADD) || (key_code == KEY_SUB);
  assign do_clear = key_valid && ((key_code == KEY_CLR) || (state == SHOW && is_digit));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ENTER_1;
      buf_flag_1     <= '0;
      key_buf_code_1 <= '0;
      buf_flag_2     <= '0;
      key_buf_code_2 <= '0;
      op_sub         <= 1'b0;
      busy           <= 1'b0;
      result         <= '0;
      result_flag    <= '0;
      result_neg     <= 1'b0;
      result_valid   <= 1'b0;
      x_sr           <= '0;
      y_sr           <= '0;
      acc            <= '0;
      cy             <= 1'b0;
      neg_r          <= 1'b0;
      idx            <= '0;
    end else if (do_clear) begin
      // A digit in SHOW starts a fresh calculation with that digit as operand 1.
      state          <= ENTER_1;
      buf_flag_1     <= '0;
      key_buf_code_1 <= '0;
      buf_flag_2     <= '0;
      key_buf_code_2 <= '0;
      op_sub         <= 1'b0;
      busy           <= 1'b0;
      result         <= '0;
      result_flag    <= '0;
      result_neg     <= 1'b0;
      result_valid   <= 1'b0;
      x_sr           <= '0;
      y_sr           <= '0;
      acc            <= '0;
      cy             <= 1'b0;
      neg_r          <= 1'b0;
      idx            <= '0;
      if (key_code != KEY_CLR) begin
        key_buf_code_1 <= {{(DW-4){1'b0}}, key_code};
        buf_flag_1     <= {{(DIGITS-1){1'b0}}, 1'b1};
      end
    end else begin
      case (state)
        ENTER_1: if (key_valid) begin
          if (is_digit) begin
            if (!(&buf_flag_1)) begin
              key_buf_code_1 <= {key_buf_code_1[DW-5:0], key_code};
              buf_flag_1     <= {buf_flag_1[DIGITS-2:0], 1'b1};
            end
          end else if (key_code == KEY_BS) begin
            key_buf_code_1 <= {4'h0, key_buf_code_1[DW-1:4]};
            buf_flag_1     <= {1'b0, buf_flag_1[DIGITS-1:1]};
          end else if (is_op) begin
            op_sub <= (key_code == KEY_SUB);
            state  <= ENTER_2;
          end
        end
        ENTER_2: if (key_valid) begin
          if (is_digit) begin
            if (!(&buf_flag_2)) begin
              key_buf_code_2 <= {key_buf_code_2[DW-5:0], key_code};
              buf_flag_2     <= {buf_flag_2[DIGITS-2:0], 1'b1};
            end
          end else if (key_code == KEY_BS) begin
            key_buf_code_2 <= {4'h0, key_buf_code_2[DW-1:4]};
            buf_flag_2     <= {1'b0, buf_flag_2[DIGITS-1:1]};
          end else if (is_op) begin
            if (buf_flag_2 == '0) op_sub <= (key_code == KEY_SUB);
          end else if (key_code == KEY_EQ) begin
            state <= CALC;
            busy  <= 1'b1;
            idx   <= '0;
          end
        end
        CALC: begin
          if (idx == '0) begin
            // Subtract always runs larger minus smaller; the sign is kept aside.
            if (op_sub && (key_buf_code_1 < key_buf_code_2)) begin
              x_sr  <= key_buf_code_2;
              y_sr  <= key_buf_code_1;
              neg_r <= 1'b1;
            end else begin
              x_sr  <= key_buf_code_1;
              y_sr  <= key_buf_code_2;
              neg_r <= 1'b0;
            end
            cy  <= 1'b0;
            acc <= '0;
            idx <= idx + 1'b1;
          end else begin
            x_sr <= {4'h0, x_sr[DW-1:4]};
            y_sr <= {4'h0, y_sr[DW-1:4]};
            cy   <= cy_next;
            acc  <= {dig, acc[DW-1:4]};
            if (idx == IDX_LAST) begin
              result       <= mag;
              result_flag  <= sig_mask(mag);
              result_neg   <= neg_r && (mag != '0);
              busy         <= 1'b0;
              result_valid <= 1'b1;
              state        <= SHOW;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_calc_core.sv
// tb/tb_keypad_calc_core.sv - directed vector bench for keypad_calc_core
module tb_keypad_calc_core;

  localparam int DEB = 4;
  localparam int REL = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        press = 1'b0;
  logic [3:0]  scan_code = 4'h0;
  logic        key_valid;
  logic [4:0]  buf_flag_1, buf_flag_2;
  logic [19:0] key_buf_code_1, key_buf_code_2;
  logic        op_sub, busy;
  logic [23:0] result;
  logic [5:0]  result_flag;
  logic        result_neg, result_valid;

  keypad_calc_core #(.DIGITS(5), .DEB_CYCLES(DEB), .REL_CYCLES(REL)) dut (
    .clk(clk), .rst(rst), .press(press), .scan_code(scan_code),
    .key_valid(key_valid),
    .buf_flag_1(buf_flag_1), .key_buf_code_1(key_buf_code_1),
    .buf_flag_2(buf_flag_2), .key_buf_code_2(key_buf_code_2),
    .op_sub(op_sub), .busy(busy),
    .result(result), .result_flag(result_flag),
    .result_neg(result_neg), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int kv_cnt = 0;
  int busy_cnt = 0;

  typedef struct {
    logic [19:0] a;
    int          na;
    logic [19:0] b;
    int          nb;
    logic        sub;
    logic [23:0] res;
    logic [5:0]  flg;
    logic        neg;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (key_valid) kv_cnt++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic key(input logic [3:0] c);
    scan_code = c;
    press = 1'b1;
    idle(DEB + 3);
    press = 1'b0;
    idle(REL + 2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{20'h00123, 3, 20'h00045, 2, 1'b0, 24'h000168, 6'b000111, 1'b0};
    vecs[1] = '{20'h99999, 5, 20'h99999, 5, 1'b0, 24'h199998, 6'b111111, 1'b0};
    vecs[2] = '{20'h00012, 2, 20'h00345, 3, 1'b1, 24'h000333, 6'b000111, 1'b1};
    vecs[3] = '{20'h00007, 1, 20'h00007, 1, 1'b1, 24'h000000, 6'b000001, 1'b0};
    vecs[4] = '{20'h00500, 3, 20'h00001, 1, 1'b1, 24'h000499, 6'b000111, 1'b0};
    vecs[5] = '{20'h00000, 0, 20'h00005, 1, 1'b0, 24'h000005, 6'b000001, 1'b0};
    vecs[6] = '{20'h10000, 5, 20'h99999, 5, 1'b1, 24'h089999, 6'b011111, 1'b1};
    vecs[7] = '{20'h99999, 5, 20'h00001, 1, 1'b0, 24'h100000, 6'b111111, 1'b0};
    vecs[8] = '{20'h00000, 1, 20'h00000, 1, 1'b1, 24'h000000, 6'b000001, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_key_valid", {31'b0, key_valid}, 32'h0);
    chk("reset_code_1", {12'b0, key_buf_code_1}, 32'h0);
    chk("reset_result", {8'b0, result}, 32'h0);
    chk("reset_flags", {16'b0, buf_flag_1, buf_flag_2, result_flag}, 32'h0);
    chk("reset_status", {28'b0, op_sub, busy, result_neg, result_valid}, 32'h0);
    rst = 1'b1;

    // Debounce corner cases with key 5 and a stable scan code.
    scan_code = 4'h5;
    idle(4);
    kv_cnt = 0;
    press = 1'b1; idle(3);
    press = 1'b0; idle(1);
    press = 1'b1; idle(3);
    press = 1'b0; idle(20);
    chk("deb_short_glitch", kv_cnt, 0);
    press = 1'b1; idle(200);
    chk("deb_held_200", kv_cnt, 1);
    press = 1'b0; idle(10);
    press = 1'b1; idle(10);
    chk("deb_release_10", kv_cnt, 1);
    press = 1'b0; idle(16);
    press = 1'b1; idle(10);
    chk("deb_release_16", kv_cnt, 2);
    press = 1'b0; idle(20);
    chk("deb_code_1", {12'b0, key_buf_code_1}, 32'h00055);
    chk("deb_flag_1", {27'b0, buf_flag_1}, 32'h03);

    // Overflow of operand 1 and backspace.
    key(4'hC);
    kv_cnt = 0;
    for (int d = 1; d <= 6; d++) key(4'(d));
    chk("ovf_key_valid", kv_cnt, 6);
    chk("ovf_code_1", {12'b0, key_buf_code_1}, 32'h12345);
    chk("ovf_flag_1", {27'b0, buf_flag_1}, 32'h1F);
    key(4'hF);
    chk("bs_code_1", {12'b0, key_buf_code_1}, 32'h01234);
    chk("bs_flag_1", {27'b0, buf_flag_1}, 32'h0F);

    for (int v = 0; v < 9; v++) begin
      key(4'hC);
      for (int i = vecs[v].na - 1; i >= 0; i--) key(vecs[v].a[4*i +: 4]);
      key(vecs[v].sub ? 4'hB : 4'hA);
      for (int i = vecs[v].nb - 1; i >= 0; i--) key(vecs[v].b[4*i +: 4]);
      chk($sformatf("v%0d_code_1", v), {12'b0, key_buf_code_1}, {12'b0, vecs[v].a});
      chk($sformatf("v%0d_code_2", v), {12'b0, key_buf_code_2}, {12'b0, vecs[v].b});
      chk($sformatf("v%0d_op_sub", v), {31'b0, op_sub}, {31'b0, vecs[v].sub});
      busy_cnt = 0;
      key(4'hE);
      chk($sformatf("v%0d_busy_cycles", v), busy_cnt, 6);
      chk($sformatf("v%0d_result_valid", v), {31'b0, result_valid}, 32'h1);
      chk($sformatf("v%0d_result", v), {8'b0, result}, {8'b0, vecs[v].res});
      chk($sformatf("v%0d_result_flag", v), {26'b0, result_flag}, {26'b0, vecs[v].flg});
      chk($sformatf("v%0d_result_neg", v), {31'b0, result_neg}, {31'b0, vecs[v].neg});
    end

    // A digit in SHOW clears and starts operand 1.
    key(4'h8);
    chk("show_digit_valid", {31'b0, result_valid}, 32'h0);
    chk("show_digit_result", {8'b0, result}, 32'h0);
    chk("show_digit_code_1", {12'b0, key_buf_code_1}, 32'h8);
    chk("show_digit_flag_1", {27'b0, buf_flag_1}, 32'h1);

    // Clear during ENTER_2.
    key(4'hC);
    key(4'h1); key(4'hB); key(4'h2);
    chk("e2_op_sub", {31'b0, op_sub}, 32'h1);
    chk("e2_code_2", {12'b0, key_buf_code_2}, 32'h2);
    key(4'hC);
    chk("clr_codes", {key_buf_code_1, 12'b0} | {12'b0, key_buf_code_2}, 32'h0);
    chk("clr_flags_op", {21'b0, buf_flag_1, buf_flag_2, op_sub}, 32'h0);

    // Asynchronous reset in the middle of CALC.
    key(4'h3); key(4'hA); key(4'h4);
    scan_code = 4'hE;
    press = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 40 && busy_cnt < 3; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    chk("calc_reached_busy", busy_cnt, 3);
    #2 rst = 1'b0;
    #1;
    chk("arst_status", {28'b0, busy, result_valid, result_neg, op_sub}, 32'h0);
    chk("arst_result", {8'b0, result}, 32'h0);
    chk("arst_buffers", {key_buf_code_1, 12'b0} | {12'b0, key_buf_code_2}, 32'h0);
    chk("arst_flags", {16'b0, buf_flag_1, buf_flag_2, result_flag}, 32'h0);
    @(negedge clk);
    press = 1'b0;
    rst = 1'b1;
    idle(4);
    key(4'h7);
    chk("arst_enter_1_code", {12'b0, key_buf_code_1}, 32'h7);
    chk("arst_enter_1_code_2", {12'b0, key_buf_code_2}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_calc_core.md
Name: keypad_calc_core

Overview:
- Parametrised successor to the two-operand keypad adder buffer.
- Sits between the keyboard decoder (press / scan_code) and the 7-segment display driver.
- Debounces key events and collects two BCD operands of DIGITS digits each, with backspace, clear and operator editing.
- Performs a digit-serial BCD add or subtract with sign and publishes a flagged result.

Parameters:
DIGITS, 5, BCD digits per operand; result has DIGITS+1 digits.
DEB_CYCLES, 4, consecutive cycles press must be high with a stable scan_code before a key is accepted.
REL_CYCLES, 16, consecutive cycles press must be low before the next key is armed; must exceed one kr_scan period.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
press  in  1  key-down indication from the keyboard decoder
scan_code  in  4  key code: 0-9 digit, A add, B subtract, C clear, E equals, F backspace, D ignored
key_valid  out  1  one-cycle pulse when a key is accepted
buf_flag_1  out  DIGITS  digit-valid mask, operand 1 (bit i = digit i entered, LSD = bit 0)
key_buf_code_1  out  4*DIGITS  operand 1 BCD, MSD in top nibble
buf_flag_2  out  DIGITS  digit-valid mask, operand 2
key_buf_code_2  out  4*DIGITS  operand 2 BCD
op_sub  out  1  latched operator: 0 add, 1 subtract
busy  out  1  high during CALC
result  out  4*(DIGITS+1)  magnitude in BCD
result_flag  out  DIGITS+1  significant-digit mask; leading zeros cleared, bit 0 always set
result_neg  out  1  result is negative
result_valid  out  1  high while in SHOW

Behaviour:
Reset (rst low, asynchronous):
- All outputs and registers go to 0.
- FSM goes to ENTER_1; debouncer is armed.
- Reset asserted mid-CALC aborts the calculation with no partial result.

Debounce:
- The stable counter increments while press=1 and scan_code equals the previous cycle's value; otherwise it clears.
- When the counter reaches DEB_CYCLES and the debouncer is armed, the key is accepted: key_valid pulses for 1 cycle, and the debouncer disarms.
- The debouncer re-arms after press=0 for REL_CYCLES consecutive cycles.
- A held key yields exactly one acceptance.
- Buffers update on the edge after key_valid (1-cycle latency).

FSM states and transitions:
- ENTER_1:
  - Digit: if buf_flag_1 is not all ones, shift code_1 left one nibble, insert the digit at the LSD, and shift a 1 into the flag LSD. If the buffer is full, the digit is ignored but key_valid still pulses.
  - F: shift code_1 and flag right one nibble/bit, zero-filling the top.
  - A/B: latch op_sub, go to ENTER_2. An empty operand counts as 0.
  - E: ignored.
- ENTER_2:
  - Digit/F: same rules as ENTER_1, applied to operand 2.
  - A/B: overwrite op_sub only if buf_flag_2 is zero; otherwise ignored.
  - E: go to CALC.
- CALC (busy=1, all keys ignored except C), DIGITS+1 cycles:
  - Cycle 0:
    - Add: X=op1, Y=op2, neg=0.
    - Subtract: unsigned compare of the packed BCD vectors. If op1>=op2, X=op1, Y=op2, neg=0; else swap and neg=1.
    - Clear the carry/borrow.
  - Cycles 1..DIGITS: one digit per cycle, LSD first.
    - Add: s = x + y + c; if s > 9 then s = s + 6 and c = 1.
    - Subtract: d = x - y - b; if negative, d = d + 10 and b = 1.
  - After the last digit: result MSD = final carry for add, 0 for subtract.
  - result_flag is computed: each bit set if that digit or any higher digit is non-zero; bit 0 forced to 1.
  - result_neg is set only if the magnitude is non-zero.
  - Go to SHOW.
- SHOW (result_valid=1):
  - Digit: clear everything, then enter that digit into operand 1; go to ENTER_1.
  - A/B/E/F: ignored.
- C in any state: synchronous clear of all buffers, result and flags; go to ENTER_1.

Invariants:
- result and result_neg change only at CALC completion or on clear/reset.
- Operand buffers hold their values through CALC and SHOW.

Test Plan:
1. DIGITS=5. Keys 1,2,3,A,4,5,E -> code_1=0x00123, flag_1=00111, code_2=0x00045; busy high for exactly 6 cycles; then result=0x000168, result_flag=000111, result_neg=0, result_valid=1.
2. 99999 A 99999 E -> result=0x199998, result_flag=111111, result_neg=0.
3. 12 B 345 E -> result=0x000333, result_neg=1. Also 7 B 7 E -> result=0x000000, result_flag=000001, result_neg=0.
4. Keys 1..6 into operand 1 -> code_1=0x12345, flag_1=11111, sixth digit dropped with key_valid still pulsing; then F -> code_1=0x01234, flag_1=01111.
5. Debounce:
   - press high 3 cycles, low 1 cycle, high 3 cycles -> no key_valid.
   - Key 5 held 200 cycles -> exactly one key_valid.
   - press low 10 cycles, then high again -> no new key.
   - press low 16 cycles, then held high -> second key accepted.
6. Reset and clear mid-operation:
   - rst low during CALC cycle 3 -> all outputs 0 asynchronously; FSM in ENTER_1 after release.
   - C during ENTER_2 -> all buffers 0 on the next edge.
